// File: rtl/dht22_pkg.sv
// ----------------------------------------------------------------------------
// dht22_pkg
// Shared definitions for the DHT22 sensor responder: FSM state encoding,
// protocol timing constants (in microseconds) and the frame checksum helper.
// ----------------------------------------------------------------------------
package dht22_pkg;

    typedef enum logic [2:0] {
        IDLE,
        HOST_LOW,
        WAIT_RESP,
        RESP_LOW,
        RESP_HIGH,
        BIT_LOW,
        BIT_HIGH,
        END_LOW
    } state_e;

    localparam int T_WAIT_US    = 30;
    localparam int T_RESP_US    = 80;
    localparam int T_BIT_LOW_US = 50;
    localparam int T_ZERO_US    = 26;
    localparam int T_ONE_US     = 70;
    localparam int T_END_US     = 50;
    localparam int FRAME_BITS   = 40;

    localparam int US_CNT_W = 16;

    // The timer expires on the tick that follows a count of zero, so an
    // interval of N microseconds is loaded as N-1.
    function automatic logic [US_CNT_W-1:0] us_load(input int us);
        return US_CNT_W'(us - 1);
    endfunction

    // Byte-wise sum modulo 256; the 8-bit result width drops the carry.
    function automatic logic [7:0] frame_checksum(input logic [15:0] hum,
                                                  input logic [15:0] temp);
        return hum[15:8] + hum[7:0] + temp[15:8] + temp[7:0];
    endfunction

endpackage

// File: rtl/dht22_timer_if.sv
// ----------------------------------------------------------------------------
// dht22_timer_if
// Link between the responder FSM (master) and the microsecond timer (slave).
//   load     : reload the down-counter and restart the prescaler
//   load_us  : interval to load, already converted with us_load()
//   us_tick  : one-cycle strobe per elapsed microsecond
//   done     : interval expired (counter at zero on a microsecond tick)
// ----------------------------------------------------------------------------
interface dht22_timer_if;
    import dht22_pkg::*;

    logic                load;
    logic [US_CNT_W-1:0] load_us;
    logic                us_tick;
    logic                done;

    modport master (output load, output load_us, input us_tick, input done);
    modport slave  (input load, input load_us, output us_tick, output done);

endinterface

// File: rtl/dht22_us_timer.sv
// ----------------------------------------------------------------------------
// dht22_us_timer
// Microsecond prescaler plus a loadable down-counter with a done flag.
// Ports:
//   clock   : system clock (TICKS_PER_US cycles per microsecond)
//   reset_n : asynchronous active-low reset
//   tmr     : timer link, slave side
// ----------------------------------------------------------------------------
module dht22_us_timer
    import dht22_pkg::*;
#(
    parameter int TICKS_PER_US = 1
) (
    input  logic          clock,
    input  logic          reset_n,
    dht22_timer_if.slave  tmr
);

    localparam int PRE_W = (TICKS_PER_US > 1) ? $clog2(TICKS_PER_US) : 1;

    logic [PRE_W-1:0]    pre_q, pre_d;
    logic [US_CNT_W-1:0] cnt_q, cnt_d;

    assign tmr.us_tick = (pre_q == PRE_W'(TICKS_PER_US - 1));
    assign tmr.done    = tmr.us_tick && (cnt_q == '0);

    // NOTE: every variable gets its hold value before the branches, so no
    // path through this block can leave it unassigned and infer a latch.
    always_comb begin
        pre_d = pre_q;
        cnt_d = cnt_q;
        if (tmr.load) begin
            pre_d = '0;
            cnt_d = tmr.load_us;
        end else begin
            if (tmr.us_tick) begin
                pre_d = '0;
            end else begin
                pre_d = pre_q + PRE_W'(1);
            end
            if (tmr.us_tick && (cnt_q != '0)) begin
                cnt_d = cnt_q - US_CNT_W'(1);
            end
        end
    end

    // NOTE: state registers update with non-blocking assignments so every
    // flop samples the pre-edge value of its inputs.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pre_q <= '0;
            cnt_q <= '0;
        end else begin
            pre_q <= pre_d;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/dht22_responder.sv
// ----------------------------------------------------------------------------
// dht22_responder
// Emulates a DHT22 humidity/temperature sensor on an open-drain single-wire
// bus. A host low pulse of at least START_MIN_US starts a frame: response
// low/high, 40 data bits (humidity, temperature, checksum; MSB first) and a
// closing low pulse.
// Ports:
//   clock         : system clock, TICKS_PER_US cycles per microsecond
//   reset_n       : asynchronous active-low reset, releases the bus at once
//   dht22_sda     : open-drain bus, driven only to 0 or left high-Z
//   humidity      : value to send, tenths of %RH (latched at start)
//   temperature   : value to send, bit15 sign, [14:0] tenths of degC
//   corrupt_cksum : (DHT22_FAULT_INJECT_EN only) flip checksum bit 0
//   busy          : high from WAIT_RESP entry until the bus is released
//   frame_done    : one-cycle pulse after each transmitted frame
// Build option: define DHT22_FAULT_INJECT_EN to add the corrupt_cksum port.
// ----------------------------------------------------------------------------
module dht22_responder
    import dht22_pkg::*;
#(
    parameter int TICKS_PER_US = 1,
    parameter int START_MIN_US = 500
) (
    input  logic        clock,
    input  logic        reset_n,
    inout  wire         dht22_sda,
    input  logic [15:0] humidity,
    input  logic [15:0] temperature,
`ifdef DHT22_FAULT_INJECT_EN
    input  logic        corrupt_cksum,
`endif
    output logic        busy,
    output logic        frame_done
);

    localparam logic [US_CNT_W-1:0] START_MIN_CNT = US_CNT_W'(START_MIN_US);
    localparam logic [5:0]          LAST_BIT      = 6'(FRAME_BITS - 1);

    dht22_timer_if tmr_if ();

    dht22_us_timer #(
        .TICKS_PER_US (TICKS_PER_US)
    ) u_timer (
        .clock   (clock),
        .reset_n (reset_n),
        .tmr     (tmr_if)
    );

    state_e              state_q, state_d;
    logic                sda_meta_q, sda_sync_q;
    logic [US_CNT_W-1:0] host_us_q, host_us_d;
    logic [5:0]          bit_idx_q, bit_idx_d;
    logic [39:0]         frame_q, frame_d;
    logic                frame_done_q, frame_done_d;
    logic [7:0]          cksum_tx;
    logic                drive_low;

`ifdef DHT22_FAULT_INJECT_EN
    assign cksum_tx = frame_checksum(humidity, temperature) ^ {7'b0, corrupt_cksum};
`else
    assign cksum_tx = frame_checksum(humidity, temperature);
`endif

    // Drive and busy decode straight from the asynchronously reset state
    // register, so reset releases the bus without waiting for a clock edge.
    assign drive_low  = (state_q == RESP_LOW) || (state_q == BIT_LOW) ||
                        (state_q == END_LOW);
    assign busy       = (state_q != IDLE) && (state_q != HOST_LOW);
    assign frame_done = frame_done_q;
    assign dht22_sda  = drive_low ? 1'b0 : 1'bz;

    always_comb begin
        state_d        = state_q;
        host_us_d      = host_us_q;
        bit_idx_d      = bit_idx_q;
        frame_d        = frame_q;
        frame_done_d   = 1'b0;
        tmr_if.load    = 1'b0;
        tmr_if.load_us = '0;

        case (state_q)
            IDLE: begin
                if (!sda_sync_q) begin
                    state_d     = HOST_LOW;
                    host_us_d   = '0;
                    tmr_if.load = 1'b1;   // align the prescaler to the falling edge
                end
            end
            HOST_LOW: begin
                if (sda_sync_q) begin
                    if (host_us_q >= START_MIN_CNT) begin
                        state_d        = WAIT_RESP;
                        frame_d        = {humidity, temperature, cksum_tx};
                        tmr_if.load    = 1'b1;
                        tmr_if.load_us = us_load(T_WAIT_US);
                    end else begin
                        state_d = IDLE;
                    end
                end else if (tmr_if.us_tick && (host_us_q != '1)) begin
                    host_us_d = host_us_q + US_CNT_W'(1);  // saturates at max
                end
            end
            WAIT_RESP: begin
                if (tmr_if.done) begin
                    state_d        = RESP_LOW;
                    tmr_if.load    = 1'b1;
                    tmr_if.load_us = us_load(T_RESP_US);
                end
            end
            RESP_LOW: begin
                if (tmr_if.done) begin
                    state_d        = RESP_HIGH;
                    tmr_if.load    = 1'b1;
                    tmr_if.load_us = us_load(T_RESP_US);
                end
            end
            RESP_HIGH: begin
                if (tmr_if.done) begin
                    state_d        = BIT_LOW;
                    bit_idx_d      = '0;
                    tmr_if.load    = 1'b1;
                    tmr_if.load_us = us_load(T_BIT_LOW_US);
                end
            end
            BIT_LOW: begin
                // frame_q[39] is always the bit on the wire; it shifts per bit.
                if (tmr_if.done) begin
                    state_d        = BIT_HIGH;
                    tmr_if.load    = 1'b1;
                    tmr_if.load_us = frame_q[39] ? us_load(T_ONE_US)
                                                 : us_load(T_ZERO_US);
                end
            end
            BIT_HIGH: begin
                if (tmr_if.done) begin
                    tmr_if.load = 1'b1;
                    if (bit_idx_q == LAST_BIT) begin
                        state_d        = END_LOW;
                        tmr_if.load_us = us_load(T_END_US);
                    end else begin
                        state_d        = BIT_LOW;
                        bit_idx_d      = bit_idx_q + 6'd1;
                        frame_d        = {frame_q[38:0], 1'b0};
                        tmr_if.load_us = us_load(T_BIT_LOW_US);
                    end
                end
            end
            END_LOW: begin
                if (tmr_if.done) begin
                    state_d      = IDLE;
                    bit_idx_d    = '0;
                    frame_done_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            sda_meta_q   <= 1'b1;   // idle bus level, so reset is not seen as a start
            sda_sync_q   <= 1'b1;
            host_us_q    <= '0;
            bit_idx_q    <= '0;
            frame_q      <= '0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            sda_meta_q   <= dht22_sda;
            sda_sync_q   <= sda_meta_q;
            host_us_q    <= host_us_d;
            bit_idx_q    <= bit_idx_d;
            frame_q      <= frame_d;
            frame_done_q <= frame_done_d;
        end
    end

endmodule
